// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types, defaults and counter-width helper for board_io_cond
package board_io_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT,
    RUN
  } seq_state_t;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 650000;
  localparam int DEF_STARTUP_CYCLES  = 255;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - one channel: synchroniser, debounce counter, level and edge pulses
// Edge pulse registers exist only when BOARD_IO_COND_EDGE_EN is defined.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse_rise,
  output logic pulse_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   s;

  assign s     = sync_q[SYNC_STAGES-1];
  assign level = level_q;

  // Any return to the accepted level wipes the count: no partial credit for glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef BOARD_IO_COND_EDGE_EN
  logic accept;
  logic rise_q;
  logic fall_q;

  assign accept     = (s != level_q) && (cnt_q == CNT_LAST);
  assign pulse_rise = rise_q;
  assign pulse_fall = fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & s;
      fall_q <= accept & ~s;
    end
  end
`else
  assign pulse_rise = 1'b0;
  assign pulse_fall = 1'b0;
`endif

endmodule

// File: rtl/board_io_cond.sv
// rtl/board_io_cond.sv - reset sequencer from clock-wizard lock plus per-channel input debouncing
// Optional edge pulses: define BOARD_IO_COND_EDGE_EN.
module board_io_cond
  import board_io_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STARTUP_CYCLES  = DEF_STARTUP_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic [CHANNELS-1:0] raw_in,
  output logic                sys_rst_n,
  output logic                ready,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int SW = cnt_width(STARTUP_CYCLES);
  localparam logic [SW-1:0] ST_LAST = SW'(STARTUP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lk_sync_q;
  logic                   lk_s;
  seq_state_t             state_q;
  logic [SW-1:0]          st_cnt_q;
  logic                   run_q;
  logic [CHANNELS-1:0]    rise_p;
  logic [CHANNELS-1:0]    fall_p;

  assign lk_s = lk_sync_q[SYNC_STAGES-1];

  // run_q is loaded with the next-state RUN decision so it tracks state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_sync_q <= '0;
      state_q   <= WAIT_LOCK;
      st_cnt_q  <= '0;
      run_q     <= 1'b0;
    end else begin
      lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], locked};
      case (state_q)
        WAIT_LOCK: begin
          run_q <= 1'b0;
          if (lk_s) begin
            state_q  <= COUNT;
            st_cnt_q <= '0;
          end
        end
        COUNT: begin
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            run_q   <= 1'b0;
          end else if (st_cnt_q == ST_LAST) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else begin
            st_cnt_q <= st_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            run_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sys_rst_n = run_q;
  assign ready     = run_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_in[i]),
      .level     (level[i]),
      .pulse_rise(rise_p[i]),
      .pulse_fall(fall_p[i])
    );
  end

  // Pulses reach game logic only while the downstream reset is released.
  assign rise = rise_p & {CHANNELS{run_q}};
  assign fall = fall_p & {CHANNELS{run_q}};

endmodule
